gpio_in_capture: RTL and testbench
==================================

# gpio_in_capture

Input-side counterpart of the debug GPIO output mux. It samples four external GPIO input pins and synchronizes and debounces each one. Qualified edges are timestamped against system time and queued in an event FIFO that the CPU-side register logic reads. It sits beside the debug output block in the top level and is configured through the shared settings path.

## Interface
Parameters:
- DEPTH, 16, event FIFO depth; power of two, ≥2
- TS_WIDTH, 32, timestamp width

Ports:
- CLK  in  1  system clock
- RST  in  1  reset; one clock; synchronous, active-high
- GPIO_IN  in  1×4 unpacked  asynchronous input pins
- SETTINGS  in  settings::gpio_in_settings_t  ENABLE[4], EDGE[4] (2 b each), DEBOUNCE (16 b), CLEAR (1-cycle pulse)
- SYS_TIME  in  TS_WIDTH  free-running system time
- LEVEL  out  1×4 unpacked  debounced pin level
- POP  in  1  consume head event
- EVENT_VALID  out  1  FIFO non-empty
- EVENT_CH  out  2  head event channel
- EVENT_RISE  out  1  head event polarity: 1 = rising
- EVENT_TIME  out  TS_WIDTH  head event timestamp
- COUNT  out  $clog2(DEPTH)+1  FIFO occupancy
- OVERFLOW  out  1  sticky event-lost flag

## Operation
- Synchronizer: two flops per pin, giving sync[i].
- Debounce, per channel, with a 16 b counter cnt[i]:
  - sync[i]==LEVEL[i]: cnt[i] clears.
  - Otherwise, if cnt[i]≥DEBOUNCE: LEVEL[i] toggles and cnt[i] clears.
  - Otherwise: cnt[i] increments.
  - DEBOUNCE=0 toggles LEVEL on the first disagreeing cycle.
  - A synced pulse shorter than DEBOUNCE+1 cycles never changes LEVEL.
- Event qualification happens on the toggle cycle. An event is generated when ENABLE[i]=1 and EDGE[i] matches:
  - params::GPIO_EDGE_NONE=0
  - RISE=1
  - FALL=2
  - BOTH=3
- Each event records {ch, rise, SYS_TIME sampled at the toggle edge}.
- LEVEL tracks the pin regardless of ENABLE/EDGE.
- Pending stage: one entry per channel.
  - A new event for a channel whose pending entry is still full is dropped, and OVERFLOW is set.
  - Each cycle, the lowest-numbered full pending entry moves to the FIFO.
  - A pending entry may be refilled on the same edge it drains.
- FIFO:
  - Show-ahead: EVENT_CH/RISE/TIME present the head whenever EVENT_VALID=1, and are 0 when empty.
  - Push when full without a simultaneous POP: the event is dropped, it stays in pending, and OVERFLOW is set. The pending entry still drains on a later cycle.
  - Push and POP on the same edge when full: both are accepted and COUNT is unchanged.
  - POP while empty: ignored.
  - Push into an empty FIFO while POP: the POP is ignored.
- CLEAR: flushes FIFO and pending entries, zeroes COUNT, clears OVERFLOW. LEVEL, cnt and synchronizers are untouched. An event qualified on the CLEAR edge is discarded.
- Reset: synchronizers, LEVEL and cnt are 0; FIFO and pending are empty; EVENT_VALID, EVENT_CH, EVENT_RISE, EVENT_TIME, COUNT and OVERFLOW are 0.
- Reset mid-operation discards everything. A pin held high through reset produces a rising event DEBOUNCE+3 edges after reset release, if enabled.

## Timing
- A pin change sampled at edge t reaches sync at edge t+1.
- LEVEL toggles at edge E=t+2+DEBOUNCE. The timestamp is SYS_TIME at E.
- Uncontended path: pending is written at E, the FIFO is written at E+1, and EVENT_VALID rises after E+1.
- Contention adds one edge per lower-numbered pending channel.
- POP at edge P: the next head (or EVENT_VALID=0) is visible after P.
- COUNT updates on the same edge as the push/pop.
- Sustained throughput is one FIFO write per cycle.

## Structure
- settings package: gpio_in_settings_t.
- params package: GPIO_EDGE_NONE/RISE/FALL/BOTH.
- Sub-module gpio_in_fifo:
  - synchronous show-ahead FIFO with parameters DEPTH and WIDTH
  - ports: push, pop, full, empty, count, flush
- Top level contains the synchronizers, debounce counters, pending stage and priority drain.

## Test plan
- DEBOUNCE=0, ch0 ENABLE, EDGE=RISE, GPIO_IN[0] 0→1 at edge t → LEVEL[0]=1 at t+2; EVENT_VALID after t+3; EVENT_CH=0, EVENT_RISE=1, EVENT_TIME=SYS_TIME at t+2; POP → EVENT_VALID=0.
- DEBOUNCE=10, 8-cycle high glitch on ch1 → no LEVEL change, no event. A 12-cycle high pulse → LEVEL toggles 12 edges after sampling; with EDGE=BOTH, two events (rise, then fall).
- All four channels rise on the same edge, EDGE=RISE → four events in order ch0,1,2,3 on consecutive edges, identical EVENT_TIME, COUNT=4.
- DEPTH=16, no POP, 17 qualified events → COUNT=16, OVERFLOW=1, 17th held in pending. POP once → 17th enters FIFO next edge; COUNT=16.
- FIFO full, push and POP on the same edge → COUNT stays 16, head advances. CLEAR → COUNT=0, OVERFLOW=0, EVENT_VALID=0, LEVEL unchanged.
- RST asserted with 5 events queued → all outputs 0. Pin held high through RST, DEBOUNCE=3 → rising event, LEVEL=1 six edges after release.

Source files
------------

// File: rtl/gpio_in_capture_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | params / settings / gpio_in_capture_pkg                              |
// | Edge-select codes, settings bundle and shared helpers for GPIO input. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package params;
  localparam logic [1:0] GPIO_EDGE_NONE = 2'd0;
  localparam logic [1:0] GPIO_EDGE_RISE = 2'd1;
  localparam logic [1:0] GPIO_EDGE_FALL = 2'd2;
  localparam logic [1:0] GPIO_EDGE_BOTH = 2'd3;
endpackage

package settings;
  typedef struct packed {
    logic [3:0]       enable;
    logic [3:0][1:0]  edge_mode;
    logic [15:0]      debounce;
    logic             clear;
  } gpio_in_settings_t;
endpackage

package gpio_in_capture_pkg;
  localparam int c_num_ch = 4;
  localparam int c_ch_w   = 2;
  localparam int c_cnt_w  = 16;

  // True when a transition in direction 'rise' is selected by 'mode'.
  function automatic logic edge_match(input logic [1:0] mode, input logic rise);
    logic w_hit;
    w_hit = (mode == params::GPIO_EDGE_BOTH) ||
            ( rise && (mode == params::GPIO_EDGE_RISE)) ||
            (!rise && (mode == params::GPIO_EDGE_FALL));
    return w_hit;
  endfunction
endpackage
`default_nettype wire

// File: rtl/gpio_in_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpio_in_fifo                                                         |
// | Synchronous show-ahead FIFO; head reads as zero while empty.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module gpio_in_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 35
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int c_aw = $clog2(DEPTH);
  localparam logic [c_aw:0]   c_depth   = (c_aw+1)'(DEPTH);
  localparam logic [c_aw:0]   c_cnt_one = (c_aw+1)'(1);
  localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign empty = (r_count == '0);
  assign full  = (r_count == c_depth);
  // A pop on a full FIFO frees the slot the same-edge push lands in.
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= wdata;
  end

  assign rdata = empty ? '0 : r_mem[r_rd_ptr];
  assign count = r_count;
endmodule
`default_nettype wire

// File: rtl/gpio_in_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpio_in_capture                                                      |
// | Sync + debounce four GPIO inputs, timestamp edges into an event FIFO.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module gpio_in_capture
  import gpio_in_capture_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int TS_WIDTH = 32
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          GPIO_IN [c_num_ch],
  input  settings::gpio_in_settings_t   SETTINGS,
  input  logic [TS_WIDTH-1:0]           SYS_TIME,
  output logic                          LEVEL [c_num_ch],
  input  logic                          POP,
  output logic                          EVENT_VALID,
  output logic [c_ch_w-1:0]             EVENT_CH,
  output logic                          EVENT_RISE,
  output logic [TS_WIDTH-1:0]           EVENT_TIME,
  output logic [$clog2(DEPTH):0]        COUNT,
  output logic                          OVERFLOW
);
  localparam int c_ev_w = c_ch_w + 1 + TS_WIDTH;
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  logic [c_num_ch-1:0]  r_sync1;
  logic [c_num_ch-1:0]  r_sync2;
  logic [c_num_ch-1:0]  r_level;
  logic [c_cnt_w-1:0]   r_cnt [c_num_ch];

  logic [c_num_ch-1:0]  r_pend_valid;
  logic [c_num_ch-1:0]  r_pend_rise;
  logic [TS_WIDTH-1:0]  r_pend_time [c_num_ch];
  logic                 r_overflow;

  logic [c_num_ch-1:0]  w_toggle;
  logic [c_num_ch-1:0]  w_qual;
  logic [c_num_ch-1:0]  w_drained;
  logic [c_num_ch-1:0]  w_base;
  logic [c_num_ch-1:0]  w_load;
  logic [c_num_ch-1:0]  w_drop;
  logic [c_ch_w-1:0]    w_drain_sel;
  logic                 w_any;
  logic                 w_accept;
  logic                 w_full;
  logic                 w_empty;
  logic [c_ev_w-1:0]    w_wdata;
  logic [c_ev_w-1:0]    w_rdata;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_level <= '0;
      for (int i = 0; i < c_num_ch; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= {GPIO_IN[3], GPIO_IN[2], GPIO_IN[1], GPIO_IN[0]};
      r_sync2 <= r_sync1;
      for (int i = 0; i < c_num_ch; i++) begin
        if (r_sync2[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] >= SETTINGS.debounce) begin
          r_level[i] <= ~r_level[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + c_cnt_one;
        end
      end
    end
  end

  for (genvar g = 0; g < c_num_ch; g++) begin : g_ch
    assign w_toggle[g] = (r_sync2[g] != r_level[g]) && (r_cnt[g] >= SETTINGS.debounce);
    // The new level after a toggle is the inverse of the current one.
    assign w_qual[g]   = w_toggle[g] && SETTINGS.enable[g] &&
                         edge_match(SETTINGS.edge_mode[g], ~r_level[g]);
    assign LEVEL[g]    = r_level[g];
  end

  always_comb begin
    w_drain_sel = '0;
    for (int i = c_num_ch - 1; i >= 0; i--) begin
      if (r_pend_valid[i]) w_drain_sel = c_ch_w'(i);
    end
  end

  assign w_any     = |r_pend_valid;
  assign w_accept  = w_any && (!w_full || POP);
  assign w_drained = w_accept ? (c_num_ch'(1) << w_drain_sel) : '0;
  // Occupancy after this edge's drain, so a draining entry can be refilled.
  assign w_base    = r_pend_valid & ~w_drained;
  assign w_load    = w_qual & ~w_base;
  assign w_drop    = w_qual &  w_base;

  always_ff @(posedge CLK) begin
    if (RST || SETTINGS.clear) begin
      r_pend_valid <= '0;
      r_pend_rise  <= '0;
      r_overflow   <= 1'b0;
      for (int i = 0; i < c_num_ch; i++) r_pend_time[i] <= '0;
    end else begin
      r_pend_valid <= w_base | w_load;
      r_overflow   <= r_overflow || (|w_drop) || (w_any && !w_accept);
      for (int i = 0; i < c_num_ch; i++) begin
        if (w_load[i]) begin
          r_pend_rise[i] <= ~r_level[i];
          r_pend_time[i] <= SYS_TIME;
        end
      end
    end
  end

  assign w_wdata = {w_drain_sel, r_pend_rise[w_drain_sel], r_pend_time[w_drain_sel]};

  gpio_in_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (c_ev_w)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .flush (SETTINGS.clear),
    .push  (w_any),
    .wdata (w_wdata),
    .pop   (POP),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty),
    .count (COUNT)
  );

  assign EVENT_VALID = !w_empty;
  assign EVENT_CH    = w_rdata[c_ev_w-1 -: c_ch_w];
  assign EVENT_RISE  = w_rdata[TS_WIDTH];
  assign EVENT_TIME  = w_rdata[TS_WIDTH-1:0];
  assign OVERFLOW    = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_gpio_in_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gpio_in_capture                                                   |
// | Scenario tasks with a queue of expected events for gpio_in_capture.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_gpio_in_capture;
  logic                        CLK = 1'b0;
  logic                        RST;
  logic                        GPIO_IN [4];
  settings::gpio_in_settings_t SETTINGS;
  logic [31:0]                 SYS_TIME = '0;
  logic                        LEVEL [4];
  logic                        POP;
  logic                        EVENT_VALID;
  logic [1:0]                  EVENT_CH;
  logic                        EVENT_RISE;
  logic [31:0]                 EVENT_TIME;
  logic [4:0]                  COUNT;
  logic                        OVERFLOW;
  logic [3:0]                  lv;

  typedef struct {
    logic [1:0]  ch;
    logic        rise;
    logic [31:0] t;
  } ev_t;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) SYS_TIME <= SYS_TIME + 32'd1;
  always_comb lv = {LEVEL[3], LEVEL[2], LEVEL[1], LEVEL[0]};

  gpio_in_capture #(.DEPTH(16), .TS_WIDTH(32)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .GPIO_IN     (GPIO_IN),
    .SETTINGS    (SETTINGS),
    .SYS_TIME    (SYS_TIME),
    .LEVEL       (LEVEL),
    .POP         (POP),
    .EVENT_VALID (EVENT_VALID),
    .EVENT_CH    (EVENT_CH),
    .EVENT_RISE  (EVENT_RISE),
    .EVENT_TIME  (EVENT_TIME),
    .COUNT       (COUNT),
    .OVERFLOW    (OVERFLOW)
  );

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_valid(output bit ok);
    for (int i = 0; i < 40 && !EVENT_VALID; i++) tick();
    ok = EVENT_VALID;
  endtask

  task automatic pop_once();
    POP = 1'b1;
    tick();
    POP = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; POP = 1'b0; SETTINGS = '0;
    for (int i = 0; i < 4; i++) GPIO_IN[i] = 1'b0;
    ticks(3);
    RST = 1'b0;
    tick();
    n_checks++;
    if ({EVENT_VALID, COUNT, OVERFLOW} !== 7'd0) $display("FAIL reset_ctl: valid=%b count=%0d ovf=%b, want 0", EVENT_VALID, COUNT, OVERFLOW);
    else n_pass++;
    n_checks++;
    if ({EVENT_CH, EVENT_RISE, EVENT_TIME, lv} !== 39'd0) $display("FAIL reset_data: ch=%0d rise=%b time=%0d level=%b, want 0", EVENT_CH, EVENT_RISE, EVENT_TIME, lv);
    else n_pass++;
  endtask

  task automatic test_single_rise();
    bit ok; ev_t e;
    SETTINGS.enable = 4'b0001; SETTINGS.edge_mode[0] = params::GPIO_EDGE_RISE; SETTINGS.debounce = 16'd0;
    GPIO_IN[0] = 1'b1;
    sb.push_back('{2'd0, 1'b1, SYS_TIME + 32'd2});
    ticks(2);
    n_checks++;
    if (lv[0] !== 1'b0) $display("FAIL single_level_early: got %b want 0", lv[0]); else n_pass++;
    tick();
    n_checks++;
    if (lv[0] !== 1'b1 || EVENT_VALID !== 1'b0) $display("FAIL single_toggle: level=%b valid=%b want 1/0", lv[0], EVENT_VALID); else n_pass++;
    tick();
    n_checks++;
    if (EVENT_VALID !== 1'b1) $display("FAIL single_valid_latency: got %b want 1", EVENT_VALID); else n_pass++;
    wait_valid(ok); e = sb.pop_front();
    n_checks++;
    if (ok && EVENT_CH === e.ch && EVENT_RISE === e.rise && EVENT_TIME === e.t) n_pass++;
    else $display("FAIL single_event: got v=%b ch=%0d r=%b t=%0d want ch=%0d r=%b t=%0d", ok, EVENT_CH, EVENT_RISE, EVENT_TIME, e.ch, e.rise, e.t);
    pop_once();
    n_checks++;
    if (EVENT_VALID !== 1'b0) $display("FAIL single_pop_empty: valid=%b want 0", EVENT_VALID); else n_pass++;
    GPIO_IN[0] = 1'b0;
    ticks(6);
    n_checks++;
    if (EVENT_VALID !== 1'b0 || lv[0] !== 1'b0) $display("FAIL single_fall_ignored: valid=%b level=%b want 0/0", EVENT_VALID, lv[0]); else n_pass++;
  endtask

  task automatic test_debounce();
    bit ok; ev_t e;
    SETTINGS.enable = 4'b0010; SETTINGS.edge_mode[1] = params::GPIO_EDGE_BOTH; SETTINGS.debounce = 16'd10;
    GPIO_IN[1] = 1'b1; ticks(8); GPIO_IN[1] = 1'b0; ticks(25);
    n_checks++;
    if (lv[1] !== 1'b0 || EVENT_VALID !== 1'b0) $display("FAIL glitch_filtered: level=%b valid=%b want 0/0", lv[1], EVENT_VALID); else n_pass++;
    GPIO_IN[1] = 1'b1;
    sb.push_back('{2'd1, 1'b1, SYS_TIME + 32'd12});
    ticks(12);
    n_checks++;
    if (lv[1] !== 1'b0) $display("FAIL debounce_early: level=%b want 0", lv[1]); else n_pass++;
    GPIO_IN[1] = 1'b0;
    sb.push_back('{2'd1, 1'b0, SYS_TIME + 32'd12});
    tick();
    n_checks++;
    if (lv[1] !== 1'b1) $display("FAIL debounce_toggle: level=%b want 1", lv[1]); else n_pass++;
    for (int k = 0; k < 2; k++) begin
      wait_valid(ok); e = sb.pop_front();
      n_checks++;
      if (ok && EVENT_CH === e.ch && EVENT_RISE === e.rise && EVENT_TIME === e.t) n_pass++;
      else $display("FAIL debounce_event%0d: got v=%b ch=%0d r=%b t=%0d want ch=%0d r=%b t=%0d", k, ok, EVENT_CH, EVENT_RISE, EVENT_TIME, e.ch, e.rise, e.t);
      pop_once();
    end
  endtask

  task automatic test_all_four();
    bit ok; ev_t e;
    SETTINGS.enable = 4'hF; SETTINGS.debounce = 16'd0;
    for (int i = 0; i < 4; i++) SETTINGS.edge_mode[i] = params::GPIO_EDGE_RISE;
    for (int i = 0; i < 4; i++) begin
      GPIO_IN[i] = 1'b1;
      sb.push_back('{2'(i), 1'b1, SYS_TIME + 32'd2});
    end
    ticks(3);
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_checks++;
      if (COUNT !== 5'(k)) $display("FAIL all4_count_step%0d: got %0d want %0d", k, COUNT, k); else n_pass++;
    end
    for (int k = 0; k < 4; k++) begin
      wait_valid(ok); e = sb.pop_front();
      n_checks++;
      if (ok && EVENT_CH === e.ch && EVENT_RISE === e.rise && EVENT_TIME === e.t) n_pass++;
      else $display("FAIL all4_event%0d: got v=%b ch=%0d r=%b t=%0d want ch=%0d r=%b t=%0d", k, ok, EVENT_CH, EVENT_RISE, EVENT_TIME, e.ch, e.rise, e.t);
      pop_once();
    end
    for (int i = 0; i < 4; i++) GPIO_IN[i] = 1'b0;
    ticks(6);
  endtask

  logic ch2_lvl;

  task automatic test_overflow();
    SETTINGS.enable = 4'b0100; SETTINGS.edge_mode[2] = params::GPIO_EDGE_BOTH; SETTINGS.debounce = 16'd0;
    ch2_lvl = 1'b0;
    for (int k = 0; k < 17; k++) begin
      ch2_lvl = ~ch2_lvl;
      GPIO_IN[2] = ch2_lvl;
      sb.push_back('{2'd2, ch2_lvl, SYS_TIME + 32'd2});
      ticks(2);
    end
    ticks(6);
    n_checks++;
    if (COUNT !== 5'd16 || OVERFLOW !== 1'b1) $display("FAIL ovf_full: count=%0d ovf=%b want 16/1", COUNT, OVERFLOW); else n_pass++;
    n_checks++;
    if (EVENT_VALID === 1'b1 && EVENT_RISE === sb[0].rise && EVENT_TIME === sb[0].t) n_pass++;
    else $display("FAIL ovf_head: got r=%b t=%0d want r=%b t=%0d", EVENT_RISE, EVENT_TIME, sb[0].rise, sb[0].t);
    pop_once();
    void'(sb.pop_front());
    tick();
    n_checks++;
    if (COUNT !== 5'd16) $display("FAIL ovf_refill: count=%0d want 16", COUNT); else n_pass++;
    n_checks++;
    if (EVENT_RISE === sb[0].rise && EVENT_TIME === sb[0].t) n_pass++;
    else $display("FAIL ovf_head_adv: got r=%b t=%0d want r=%b t=%0d", EVENT_RISE, EVENT_TIME, sb[0].rise, sb[0].t);
  endtask

  task automatic test_back_to_back();
    ch2_lvl = ~ch2_lvl;
    GPIO_IN[2] = ch2_lvl;
    sb.push_back('{2'd2, ch2_lvl, SYS_TIME + 32'd2});
    ticks(4);
    POP = 1'b1; tick(); POP = 1'b0;
    void'(sb.pop_front());
    n_checks++;
    if (COUNT !== 5'd16) $display("FAIL b2b_count: count=%0d want 16", COUNT); else n_pass++;
    n_checks++;
    if (EVENT_RISE === sb[0].rise && EVENT_TIME === sb[0].t) n_pass++;
    else $display("FAIL b2b_head: got r=%b t=%0d want r=%b t=%0d", EVENT_RISE, EVENT_TIME, sb[0].rise, sb[0].t);
    SETTINGS.clear = 1'b1; tick(); SETTINGS.clear = 1'b0;
    sb.delete();
    n_checks++;
    if (COUNT !== 5'd0 || OVERFLOW !== 1'b0 || EVENT_VALID !== 1'b0) $display("FAIL clear_state: count=%0d ovf=%b valid=%b want 0/0/0", COUNT, OVERFLOW, EVENT_VALID);
    else n_pass++;
    ticks(3);
    n_checks++;
    if (lv[2] !== ch2_lvl || EVENT_VALID !== 1'b0) $display("FAIL clear_level: level=%b valid=%b want %b/0", lv[2], EVENT_VALID, ch2_lvl); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok; ev_t e;
    logic lvl3;
    SETTINGS.enable = 4'b1000; SETTINGS.edge_mode[3] = params::GPIO_EDGE_BOTH; SETTINGS.debounce = 16'd0;
    lvl3 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      lvl3 = ~lvl3; GPIO_IN[3] = lvl3; ticks(2);
    end
    ticks(6);
    n_checks++;
    if (COUNT !== 5'd5) $display("FAIL mid_queued: count=%0d want 5", COUNT); else n_pass++;
    SETTINGS.enable = 4'b0001; SETTINGS.edge_mode[0] = params::GPIO_EDGE_RISE; SETTINGS.debounce = 16'd3;
    GPIO_IN[0] = 1'b1;
    RST = 1'b1;
    tick();
    n_checks++;
    if ({EVENT_VALID, COUNT, OVERFLOW, EVENT_CH, EVENT_RISE, EVENT_TIME, lv} !== 46'd0)
      $display("FAIL mid_reset_zero: valid=%b count=%0d ovf=%b ch=%0d r=%b t=%0d level=%b want 0", EVENT_VALID, COUNT, OVERFLOW, EVENT_CH, EVENT_RISE, EVENT_TIME, lv);
    else n_pass++;
    tick();
    RST = 1'b0;
    sb.push_back('{2'd0, 1'b1, SYS_TIME + 32'd5});
    ticks(5);
    n_checks++;
    if (lv[0] !== 1'b0) $display("FAIL mid_level_early: level=%b want 0", lv[0]); else n_pass++;
    tick();
    n_checks++;
    if (lv[0] !== 1'b1) $display("FAIL mid_level_rise: level=%b want 1", lv[0]); else n_pass++;
    wait_valid(ok); e = sb.pop_front();
    n_checks++;
    if (ok && EVENT_CH === e.ch && EVENT_RISE === e.rise && EVENT_TIME === e.t && COUNT === 5'd1) n_pass++;
    else $display("FAIL mid_event: got v=%b ch=%0d r=%b t=%0d cnt=%0d want ch=%0d r=%b t=%0d cnt=1", ok, EVENT_CH, EVENT_RISE, EVENT_TIME, COUNT, e.ch, e.rise, e.t);
    pop_once();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_rise();
    test_debounce();
    test_all_four();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
